// File: rtl/key_cmd_pkg.sv
// Shared definitions for the keyboard command scheduler: command codes,
// PS/2 scan codes of interest and the acknowledge FSM encoding.
package key_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_UP      = 3'd1,
        CMD_DOWN    = 3'd2,
        CMD_LEFT    = 3'd3,
        CMD_RIGHT   = 3'd4,
        CMD_UNDO    = 3'd5,
        CMD_RESTART = 3'd6,
        CMD_MENU    = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [7:0] SC_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] SC_REL_PREFIX = 8'hF0;
    localparam logic [7:0] SC_EXT_UP     = 8'h75;
    localparam logic [7:0] SC_EXT_DOWN   = 8'h72;
    localparam logic [7:0] SC_EXT_LEFT   = 8'h6B;
    localparam logic [7:0] SC_EXT_RIGHT  = 8'h74;
    localparam logic [7:0] SC_W          = 8'h1D;
    localparam logic [7:0] SC_S          = 8'h1B;
    localparam logic [7:0] SC_A          = 8'h1C;
    localparam logic [7:0] SC_D          = 8'h23;
    localparam logic [7:0] SC_U          = 8'h3C;
    localparam logic [7:0] SC_R          = 8'h2D;
    localparam logic [7:0] SC_ESC        = 8'h76;

    // Arrow keys only count with the E0 prefix; letters and Esc only without it.
    function automatic cmd_e decode_scan(input logic extended, input logic [7:0] code);
        cmd_e cmd;
        cmd = CMD_NONE;
        if (extended) begin
            case (code)
                SC_EXT_UP:    cmd = CMD_UP;
                SC_EXT_DOWN:  cmd = CMD_DOWN;
                SC_EXT_LEFT:  cmd = CMD_LEFT;
                SC_EXT_RIGHT: cmd = CMD_RIGHT;
                default:      cmd = CMD_NONE;
            endcase
        end else begin
            case (code)
                SC_W:          cmd = CMD_UP;
                SC_S:          cmd = CMD_DOWN;
                SC_A:          cmd = CMD_LEFT;
                SC_D:          cmd = CMD_RIGHT;
                SC_U:          cmd = CMD_UNDO;
                SC_R:          cmd = CMD_RESTART;
                SC_ESC:        cmd = CMD_MENU;
                SC_EXT_PREFIX,
                SC_REL_PREFIX: cmd = CMD_NONE;
                default:       cmd = CMD_NONE;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/key_cmd_scheduler_fifo.sv
// Small synchronous command FIFO with occupancy count and a sticky
// overflow flag for pushes that arrive while full.
module cmd_fifo
    import key_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     push,
    input  cmd_e                     push_data,
    input  logic                     pop,
    input  logic                     clr_overflow,
    output cmd_e                     head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cmd_e             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign head_data = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so push-while-full succeeds then.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push && !do_push)  overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Turns decoded keyboard events into queued game commands, acknowledging
// each event once and filtering typematic repeats of the held key.
module key_cmd_scheduler
    import key_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_FILTER = 1
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic                          kb_data_ready,
    input  logic [7:0]                    kb_scan_code,
    input  logic                          kb_extended,
    input  logic                          kb_released,
    output logic                          kb_read,
    output logic                          cmd_valid,
    output logic [2:0]                    cmd_code,
    input  logic                          cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    state_e     state_q;
    logic       kb_read_q;
    logic [7:0] code_q;
    logic       ext_q;
    logic       rel_q;
    logic       held_valid_q;
    logic       held_ext_q;
    logic [7:0] held_code_q;

    cmd_e       ev_cmd;
    cmd_e       head_cmd;
    logic       held_match;
    logic       accept;
    logic       fifo_empty;
    logic       fifo_full_unused;

    assign ev_cmd     = decode_scan(ext_q, code_q);
    assign held_match = held_valid_q && (held_ext_q == ext_q) && (held_code_q == code_q);
    assign accept     = (state_q == ST_ACK) && !rel_q && (ev_cmd != CMD_NONE)
                        && !((REPEAT_FILTER != 0) && held_match);

    assign kb_read   = kb_read_q;
    assign cmd_valid = !fifo_empty;
    assign cmd_code  = head_cmd;

    // kb_read_q is set exactly on entry to ACK, so it mirrors the ACK state.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            kb_read_q    <= 1'b0;
            code_q       <= '0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (kb_data_ready) begin
                        code_q    <= kb_scan_code;
                        ext_q     <= kb_extended;
                        rel_q     <= kb_released;
                        kb_read_q <= 1'b1;
                        state_q   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    kb_read_q <= 1'b0;
                    if (accept) begin
                        held_valid_q <= 1'b1;
                        held_ext_q   <= ext_q;
                        held_code_q  <= code_q;
                    end else if (rel_q && held_match) begin
                        held_valid_q <= 1'b0;
                    end
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    kb_read_q <= 1'b0;
                    if (!kb_data_ready) state_q <= ST_IDLE;
                end
                default: begin
                    kb_read_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .push         (accept),
        .push_data    (ev_cmd),
        .pop          (cmd_valid && cmd_ready),
        .clr_overflow (clr_overflow),
        .head_data    (head_cmd),
        .full         (fifo_full_unused),
        .empty        (fifo_empty),
        .count        (fifo_count),
        .overflow     (overflow)
    );

endmodule

// File: doc/key_cmd_scheduler.md
KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 4, command queue entries (power of 2, 2..16); REPEAT_FILTER, default 1, 1 = suppress typematic repeats.
REQ-002 SHALL have ports: sys_clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: kb_data_ready  in  1  decoded key event available; kb_scan_code  in  8  event scan code; kb_extended  in  1  E0 prefix seen; kb_released  in  1  F0 prefix seen.
REQ-004 SHALL have port: kb_read  out  1  one-cycle acknowledge to the keyboard decoder.
REQ-005 SHALL have ports: cmd_valid  out  1  queue head valid; cmd_code  out  3  queue head command; cmd_ready  in  1  game logic accepts the head.
REQ-006 SHALL have ports: fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy; overflow  out  1  sticky drop flag; clr_overflow  in  1  clears overflow.

Function
REQ-007 SHALL run FSM IDLE -> ACK -> DRAIN -> IDLE; IDLE: kb_data_ready=1 latches code/extended/released and goes to ACK.
REQ-008 SHALL assert kb_read=1 for exactly one cycle, in ACK only; it SHALL be combinationally 0 in every other state.
REQ-009 SHALL stay in DRAIN while kb_data_ready=1 and return to IDLE on the first cycle it is 0; one event SHALL never be consumed twice.
REQ-010 SHALL decode commands: 0 NONE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 UNDO, 6 RESTART, 7 MENU.
REQ-011 SHALL map extended codes 75/72/6B/74 to UP/DOWN/LEFT/RIGHT.
REQ-012 SHALL map non-extended codes as follows: 1D/1B/1C/23 (W/S/A/D) to UP/DOWN/LEFT/RIGHT; 3C (U) to UNDO; 2D (R) to RESTART; 76 (Esc) to MENU; every other code to NONE.
REQ-013 SHALL ack and discard NONE and released events; a discarded event SHALL never be pushed.
REQ-014 SHALL keep held-key register {valid, extended, code}; an accepted make event SHALL load it.
REQ-015 SHALL clear the held-key register when a release event matches its extended and code fields.
REQ-016 SHALL, when REPEAT_FILTER=1, discard a make event that equals the valid held key (typematic repeat).
REQ-017 SHALL push the decoded command in the ACK cycle; push-to-cmd_valid latency is 1 cycle when the queue is empty.
REQ-018 SHALL present the queue head on cmd_valid/cmd_code; a pop occurs when cmd_valid and cmd_ready are both 1; cmd_code is don't-care when cmd_valid=0.
REQ-019 SHALL, on push when full with no simultaneous pop, drop the command and set overflow; push and pop in the same cycle when full SHALL succeed, with count unchanged.
REQ-020 SHALL use wrapping read/write pointers of width $clog2(FIFO_DEPTH); fifo_count SHALL be 0..FIFO_DEPTH.
REQ-021 SHALL clear overflow on clr_overflow=1; a set on the same cycle SHALL win.

Reset
REQ-022 SHALL, on reset=1 at a sys_clk edge, set: state=IDLE, kb_read=0, cmd_valid=0, fifo_count=0, overflow=0, held-key valid=0, pointers=0.
REQ-023 SHALL, on reset mid-ACK/DRAIN, abandon the event without a push; if kb_data_ready is still 1 afterwards, that event SHALL be reprocessed from IDLE.

Structure
REQ-024 SHALL take from a shared package key_cmd_pkg: command code constants, scan code constants (E0/F0 and the mapped keys), and the FSM state encoding.
REQ-025 SHALL instantiate one sub-module, cmd_fifo (parametric sync FIFO: push/pop/full/empty/count/overflow); decode and FSM stay in the top.

Verification
REQ-026 SHALL cover: event {ext=1,code=75,rel=0} -> kb_read high 1 cycle, then cmd_valid=1, cmd_code=1 next cycle.
REQ-027 SHALL cover: make 1C, repeat 1C twice, release 1C, make 1C -> exactly two LEFT (3) commands queued.
REQ-028 SHALL cover: cmd_ready=0 with 5 mapped presses (FIFO_DEPTH=4) -> fifo_count=4, overflow=1, first 4 commands in order.
REQ-029 SHALL cover: queue full, push and pop same cycle -> count stays 4, no overflow.
REQ-030 SHALL cover: unmapped code 0x16 -> acked, fifo_count stays 0.
REQ-031 SHALL cover: reset asserted in DRAIN with 2 queued -> all outputs at reset values next cycle.
